seq_div8: RTL and testbench



---
 rtl/seq_div_pkg.sv | 19 +
 rtl/trial_sub_cout.sv | 18 +
 rtl/seq_div8.sv | 124 ++++++++++++
 tb/tb_seq_div8.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared types and constants for the sequential divider
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

    // Width of a counter that must hold values 0..w inclusive
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/trial_sub_cout.sv
// rtl/trial_sub_cout.sv - trial subtraction as A + ~B + 1 with carry-out (1 = no borrow)
module trial_sub_cout #(
    parameter int N = 9
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] DIFF,
    output logic         COUT
);

    logic [N:0] w_sum;

    // One extra bit catches the carry out of the inverted-operand add
    assign w_sum = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};
    assign DIFF  = w_sum[N-1:0];
    assign COUT  = w_sum[N];

endmodule

// File: rtl/seq_div8.sv
// rtl/seq_div8.sv - multi-cycle unsigned restoring divider with valid/ready handshakes
module seq_div8
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DIV_BY_ZERO,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int CW = cnt_w(WIDTH);

    div_state_t       r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_cout;
    logic             w_take;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;

    // Shift the next dividend bit into the partial remainder, one bit wider than the operands
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};

    trial_sub_cout #(
        .N (WIDTH + 1)
    ) u_trial (
        .A    (w_rem_sh),
        .B    ({1'b0, r_dvs}),
        .DIFF (w_diff),
        .COUT (w_cout)
    );

    // Keep the difference only when there was no borrow and it fits back in WIDTH bits
    assign w_take     = w_cout & ~w_diff[WIDTH];
    assign w_rem_next = w_take ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_dvd_next = {r_dvd[WIDTH-2:0], w_take};

    // Handshake FSM and datapath; all outputs registered
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_dbz       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (IN_VALID && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        if (I1 == '0) begin
                            r_q         <= '1;
                            r_r         <= I0;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_dvd   <= I0;
                            r_dvs   <= I1;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_q         <= w_dvd_next;
                        r_r         <= w_rem_next;
                        r_dbz       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY    = r_in_ready;
    assign OUT_VALID   = r_out_valid;
    assign Q           = r_q;
    assign R           = r_r;
    assign DIV_BY_ZERO = r_dbz;

endmodule

// File: tb/tb_seq_div8.sv
// tb/tb_seq_div8.sv - self-checking bench for seq_div8
module tb_seq_div8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] I0;
    logic [7:0] I1;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] Q;
    logic [7:0] R;
    logic       DIV_BY_ZERO;
    logic       OUT_VALID;
    logic       OUT_READY;

    int checks = 0;
    int errors = 0;

    seq_div8 #(.WIDTH(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .I0          (I0),
        .I1          (I1),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .Q           (Q),
        .R           (R),
        .DIV_BY_ZERO (DIV_BY_ZERO),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
        int lat;
        int hold;
        bit poke;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Issue one operation, wait for its result, optionally stall and poke IN_VALID, then drain
    task automatic run_op(input int a, input int b, input int hold, input bit poke,
                          output int q, output int r, output int dbz, output int lat);
        int guard;
        guard = 0;
        while (!IN_READY && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        chk("in_ready_before_accept", int'(IN_READY), 1);
        I0 = 8'(a);
        I1 = 8'(b);
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        lat = 0;
        while (!OUT_VALID && lat < 50) begin
            if (poke) begin
                I0 = 8'($urandom);
                I1 = 8'($urandom);
                IN_VALID = 1'b1;
                chk("in_ready_busy", int'(IN_READY), 0);
            end
            @(negedge CLK);
            lat++;
        end
        IN_VALID = 1'b0;
        q = int'(Q);
        r = int'(R);
        dbz = int'(DIV_BY_ZERO);
        for (int k = 0; k < hold; k++) begin
            if (poke) IN_VALID = 1'b1;
            @(negedge CLK);
            chk("hold_q", int'(Q), q);
            chk("hold_r", int'(R), r);
            chk("hold_valid", int'(OUT_VALID), 1);
            chk("hold_in_ready", int'(IN_READY), 0);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("drain_out_valid", int'(OUT_VALID), 0);
        chk("drain_in_ready", int'(IN_READY), 1);
    endtask

    vec_t vecs[$];

    initial begin
        int q, r, dbz, lat;
        int a, b, eq, er;

        vecs.push_back('{200,   7,  28,   4, 0, 8, 0, 1'b0});
        vecs.push_back('{255,   1, 255,   0, 0, 8, 0, 1'b0});
        vecs.push_back('{128, 128,   1,   0, 0, 8, 0, 1'b0});
        vecs.push_back('{  3,  10,   0,   3, 0, 8, 0, 1'b0});
        vecs.push_back('{  5,   0, 255,   5, 1, 0, 0, 1'b0});
        vecs.push_back('{100,   9,  11,   1, 0, 8, 5, 1'b1});
        vecs.push_back('{  0,   5,   0,   0, 0, 8, 0, 1'b0});
        vecs.push_back('{255, 255,   1,   0, 0, 8, 2, 1'b0});
        vecs.push_back('{254, 255,   0, 254, 0, 8, 0, 1'b0});
        vecs.push_back('{  0,   0, 255,   0, 1, 0, 3, 1'b1});

        RESET = 1'b1;
        I0 = '0;
        I1 = '0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_in_ready", int'(IN_READY), 1);
        chk("reset_out_valid", int'(OUT_VALID), 0);
        chk("reset_q", int'(Q), 0);
        chk("reset_r", int'(R), 0);
        chk("reset_dbz", int'(DIV_BY_ZERO), 0);
        RESET = 1'b0;
        @(negedge CLK);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].poke, q, r, dbz, lat);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Reset during iteration 4 of 200/7
        I0 = 8'd200;
        I1 = 8'd7;
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("midreset_out_valid", int'(OUT_VALID), 0);
        chk("midreset_in_ready", int'(IN_READY), 1);
        chk("midreset_dbz", int'(DIV_BY_ZERO), 0);
        run_op(50, 6, 0, 1'b0, q, r, dbz, lat);
        chk("after_reset_q", q, 8);
        chk("after_reset_r", r, 2);
        chk("after_reset_latency", lat, 8);

        // Random operands against plain integer division
        for (int n = 0; n < 3000; n++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            run_op(a, b, int'($urandom_range(0, 2)), 1'b0, q, r, dbz, lat);
            eq = (b == 0) ? 255 : a / b;
            er = (b == 0) ? a : a % b;
            chk("rand_q", q, eq);
            chk("rand_r", r, er);
            chk("rand_dbz", dbz, (b == 0) ? 1 : 0);
            chk("rand_latency", lat, (b == 0) ? 0 : 8);
            if (b != 0) begin
                chk("rand_identity", q * b + r, a);
                chk("rand_r_below_divisor", int'(r < b), 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
